// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants and state encoding for the instruction fetch unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam int          WORD_BYTES        = 4;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_register.sv
// ============================================================================
// Module   : pc_register
// Brief    : Program counter flop with redirect / stall / increment next-PC mux
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_register
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = TEXT_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_i,
    input  logic                  stall_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    output logic [DATA_WIDTH-1:0] pc_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            // Word alignment is forced here; misalignment is judged upstream.
            pc_d = target_i & ~DATA_WIDTH'(3);
        end else if (!stall_i) begin
            pc_d = pc_q + DATA_WIDTH'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC owner and IF/ID register stage; optional fetch range checking
//            enabled by defining FETCH_BOUNDS_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = TEXT_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Target_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic [DATA_WIDTH-1:0] Pc_plus4_o,
    output logic                  Valid_o,
    output logic                  Fault_o
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_inc;
    logic                  running;
    logic                  fault_hit;
    logic                  pc_load;
    logic                  pc_hold;

    assign running = (state_q == RUN);
    assign pc_inc  = pc + DATA_WIDTH'(WORD_BYTES);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] TEXT_LIMIT =
        TEXT_BASE + DATA_WIDTH'(WORD_BYTES * MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] pc_cand;

    // Judge the PC that would be loaded this edge; a hit freezes the PC instead.
    always_comb begin
        pc_cand   = Redirect_i ? (Target_i & ~DATA_WIDTH'(3)) : pc_inc;
        fault_hit = 1'b0;
        if (running && (Redirect_i || !Stall_i)) begin
            fault_hit = (pc_cand < TEXT_BASE) || (pc_cand >= TEXT_LIMIT) ||
                        (Redirect_i && (Target_i[1:0] != 2'b00));
        end
    end

    assign Fault_o = (state_q == FAULT);
`else
    assign fault_hit = 1'b0;
    assign Fault_o   = 1'b0;
`endif

    assign pc_load = running && Redirect_i && !fault_hit;
    assign pc_hold = !running || fault_hit || Stall_i;

    pc_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (TEXT_BASE)
    ) u_pc_register (
        .clk        (clk),
        .reset      (reset),
        .redirect_i (pc_load),
        .stall_i    (pc_hold),
        .target_i   (Target_i),
        .pc_o       (pc)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        case (state_q)
            RUN: begin
                if (fault_hit) begin
                    state_d = FAULT;
                    valid_d = 1'b0;
                end else if (Redirect_i) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!Stall_i) begin
                    instr_d    = Instruction_i;
                    pc_plus4_d = pc_inc;
                    valid_d    = 1'b1;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            instr_q    <= NOP_WORD;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign Address_o     = pc;
    assign Instruction_o = instr_q;
    assign Pc_plus4_o    = pc_plus4_q;
    assign Valid_o       = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Directed self-checking bench for instruction_fetch_unit
//            (range-fault scenarios active when FETCH_BOUNDS_CHECK_EN is set).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall_i = 1'b0;
    logic        Redirect_i = 1'b0;
    logic [31:0] Target_i = '0;
    logic [31:0] Instruction_i;
    logic [31:0] Address_o;
    logic [31:0] Instruction_o;
    logic [31:0] Pc_plus4_o;
    logic        Valid_o;
    logic        Fault_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational ROM model: a known word at the text base, address-derived elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return {a[15:0] ^ 16'h1234, a[31:16]};
    endfunction

    assign Instruction_i = mem(Address_o);

    instruction_fetch_unit #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (64),
        .TEXT_BASE    (32'h0040_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Stall_i       (Stall_i),
        .Redirect_i    (Redirect_i),
        .Target_i      (Target_i),
        .Instruction_i (Instruction_i),
        .Address_o     (Address_o),
        .Instruction_o (Instruction_o),
        .Pc_plus4_o    (Pc_plus4_o),
        .Valid_o       (Valid_o),
        .Fault_o       (Fault_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Stall_i = 1'b0;
        Redirect_i = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (Address_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_addr got %h want %h", Address_o, 32'h0040_0000); end
        checks++; if (Instruction_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", Instruction_o, 32'h0); end
        checks++; if (Pc_plus4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want %h", Pc_plus4_o, 32'h0); end
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Valid_o); end
        checks++; if (Fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", Fault_o); end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        step();
        checks++; if (Instruction_o !== 32'h2008_0005) begin errors++; $display("FAIL seq_instr0 got %h want %h", Instruction_o, 32'h2008_0005); end
        checks++; if (Pc_plus4_o !== 32'h0040_0004) begin errors++; $display("FAIL seq_pc4_0 got %h want %h", Pc_plus4_o, 32'h0040_0004); end
        checks++; if (Valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid0 got %b want 1", Valid_o); end
        checks++; if (Address_o !== 32'h0040_0004) begin errors++; $display("FAIL seq_addr1 got %h want %h", Address_o, 32'h0040_0004); end
        step();
        checks++; if (Instruction_o !== mem(32'h0040_0004)) begin errors++; $display("FAIL seq_instr1 got %h want %h", Instruction_o, mem(32'h0040_0004)); end
        checks++; if (Address_o !== 32'h0040_0008) begin errors++; $display("FAIL seq_addr2 got %h want %h", Address_o, 32'h0040_0008); end
    endtask

    task automatic test_stall();
        Stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (Address_o !== 32'h0040_0008) begin errors++; $display("FAIL stall_addr[%0d] got %h want %h", i, Address_o, 32'h0040_0008); end
            checks++; if (Instruction_o !== mem(32'h0040_0004)) begin errors++; $display("FAIL stall_instr[%0d] got %h want %h", i, Instruction_o, mem(32'h0040_0004)); end
            checks++; if (Valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, Valid_o); end
        end
        Stall_i = 1'b0;
        step();
        checks++; if (Instruction_o !== mem(32'h0040_0008)) begin errors++; $display("FAIL stall_resume_instr got %h want %h", Instruction_o, mem(32'h0040_0008)); end
        checks++; if (Pc_plus4_o !== 32'h0040_000C) begin errors++; $display("FAIL stall_resume_pc4 got %h want %h", Pc_plus4_o, 32'h0040_000C); end
        checks++; if (Address_o !== 32'h0040_000C) begin errors++; $display("FAIL stall_resume_addr got %h want %h", Address_o, 32'h0040_000C); end
    endtask

    task automatic test_redirect_over_stall();
        Redirect_i = 1'b1;
        Stall_i = 1'b1;
        Target_i = 32'h0040_0020;
        step();
        Redirect_i = 1'b0;
        Stall_i = 1'b0;
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", Valid_o); end
        checks++; if (Instruction_o !== 32'h0) begin errors++; $display("FAIL redir_flush got %h want %h", Instruction_o, 32'h0); end
        checks++; if (Address_o !== 32'h0040_0020) begin errors++; $display("FAIL redir_addr got %h want %h", Address_o, 32'h0040_0020); end
        step();
        checks++; if (Instruction_o !== mem(32'h0040_0020)) begin errors++; $display("FAIL redir_instr got %h want %h", Instruction_o, mem(32'h0040_0020)); end
        checks++; if (Valid_o !== 1'b1) begin errors++; $display("FAIL redir_valid2 got %b want 1", Valid_o); end
        checks++; if (Pc_plus4_o !== 32'h0040_0024) begin errors++; $display("FAIL redir_pc4 got %h want %h", Pc_plus4_o, 32'h0040_0024); end
    endtask

    task automatic test_async_reset();
        Redirect_i = 1'b1;
        Target_i = 32'h0040_0010;
        step();
        Redirect_i = 1'b0;
        step();
        checks++; if (Address_o !== 32'h0040_0014) begin errors++; $display("FAIL areset_pre_addr got %h want %h", Address_o, 32'h0040_0014); end
        // Reset lands mid-cycle, well away from any rising edge.
        #2;
        reset = 1'b1;
        #1;
        checks++; if (Address_o !== 32'h0040_0000) begin errors++; $display("FAIL areset_addr got %h want %h", Address_o, 32'h0040_0000); end
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", Valid_o); end
        checks++; if (Instruction_o !== 32'h0) begin errors++; $display("FAIL areset_instr got %h want %h", Instruction_o, 32'h0); end
        checks++; if (Pc_plus4_o !== 32'h0) begin errors++; $display("FAIL areset_pc4 got %h want %h", Pc_plus4_o, 32'h0); end
        reset = 1'b0;
        step();
        checks++; if (Instruction_o !== 32'h2008_0005) begin errors++; $display("FAIL areset_first got %h want %h", Instruction_o, 32'h2008_0005); end
    endtask

    task automatic test_text_end();
        do_reset();
        Redirect_i = 1'b1;
        Target_i = 32'h0040_00FC;
        step();
        Redirect_i = 1'b0;
        step();
`ifdef FETCH_BOUNDS_CHECK_EN
        checks++; if (Fault_o !== 1'b1) begin errors++; $display("FAIL end_fault got %b want 1", Fault_o); end
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL end_valid got %b want 0", Valid_o); end
        checks++; if (Address_o !== 32'h0040_00FC) begin errors++; $display("FAIL end_addr got %h want %h", Address_o, 32'h0040_00FC); end
`else
        checks++; if (Fault_o !== 1'b0) begin errors++; $display("FAIL end_fault got %b want 0", Fault_o); end
        checks++; if (Address_o !== 32'h0040_0100) begin errors++; $display("FAIL end_addr got %h want %h", Address_o, 32'h0040_0100); end
        checks++; if (Instruction_o !== mem(32'h0040_00FC)) begin errors++; $display("FAIL end_instr got %h want %h", Instruction_o, mem(32'h0040_00FC)); end
`endif
    endtask

`ifdef FETCH_BOUNDS_CHECK_EN
    task automatic test_fault_misaligned();
        do_reset();
        Redirect_i = 1'b1;
        Target_i = 32'h0040_0102;
        step();
        checks++; if (Fault_o !== 1'b1) begin errors++; $display("FAIL mis_fault got %b want 1", Fault_o); end
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL mis_valid got %b want 0", Valid_o); end
        checks++; if (Address_o !== 32'h0040_0000) begin errors++; $display("FAIL mis_addr got %h want %h", Address_o, 32'h0040_0000); end
        Target_i = 32'h0040_0020;
        step();
        step();
        Redirect_i = 1'b0;
        checks++; if (Address_o !== 32'h0040_0000) begin errors++; $display("FAIL mis_locked_addr got %h want %h", Address_o, 32'h0040_0000); end
        checks++; if (Fault_o !== 1'b1) begin errors++; $display("FAIL mis_locked_fault got %b want 1", Fault_o); end
        do_reset();
        checks++; if (Fault_o !== 1'b0) begin errors++; $display("FAIL mis_cleared got %b want 0", Fault_o); end
    endtask
`else
    task automatic test_wrap_and_align();
        do_reset();
        Redirect_i = 1'b1;
        Target_i = 32'hFFFF_FFFF;
        step();
        Redirect_i = 1'b0;
        checks++; if (Address_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align_addr got %h want %h", Address_o, 32'hFFFF_FFFC); end
        step();
        checks++; if (Address_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want %h", Address_o, 32'h0); end
        checks++; if (Pc_plus4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want %h", Pc_plus4_o, 32'h0); end
        checks++; if (Instruction_o !== mem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr got %h want %h", Instruction_o, mem(32'hFFFF_FFFC)); end
        checks++; if (Valid_o !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", Valid_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_over_stall();
        test_async_reset();
        test_text_end();
`ifdef FETCH_BOUNDS_CHECK_EN
        test_fault_misaligned();
`else
        test_wrap_and_align();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
